// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-port controller.
package vdp_pkg;

    localparam logic [7:0] PORT_DATA_DEFAULT = 8'h98;
    localparam logic [7:0] PORT_CTRL_DEFAULT = 8'h99;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } vreq_state_e;

    localparam int STAT_F  = 7;
    localparam int STAT_5S = 6;
    localparam int STAT_C  = 5;

    localparam logic [2:0] REG_R1 = 3'd1;
    localparam int         R1_IE  = 5;

    localparam logic [4:0] SPRITE_NONE = 5'h1F;

    function automatic logic [13:0] ptr_next(input logic [13:0] ptr);
        return ptr + 14'd1;
    endfunction

endpackage

// File: rtl/vdp_vram_if.sv
// Single-outstanding VRAM request sequencer: one-entry command register,
// IDLE/REQ handshake and CPU stall generation.
module vdp_vram_if
    import vdp_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        q_valid_i,
    input  logic        q_we_i,
    input  logic [13:0] q_addr_i,
    input  logic [7:0]  q_wdata_i,
    input  logic        hold_i,
    input  logic        vram_ack_i,
    output logic        busy_o,
    output logic        rd_done_o,
    output logic        wait_n_o,
    output logic        vram_req_o,
    output logic        vram_we_o,
    output logic [13:0] vram_addr_o,
    output logic [7:0]  vram_wdata_o
);

    vreq_state_e state_q, state_d;
    logic        we_q, we_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    // Next state; the command is captured only when leaving IDLE
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (q_valid_i) begin
                    state_d = ST_REQ;
                    we_d    = q_we_i;
                    addr_d  = q_addr_i;
                    wdata_d = q_wdata_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (vram_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and command registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 14'h0000;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o       = (state_q == ST_REQ);
    assign vram_req_o   = busy_o;
    assign vram_we_o    = busy_o & we_q;
    assign vram_addr_o  = addr_q;
    assign vram_wdata_o = wdata_q;
    assign rd_done_o    = busy_o & vram_ack_i & ~we_q;
    assign wait_n_o     = ~(hold_i & busy_o);

endmodule

// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller of the TMS9918-style VDP: port decode, control-port
// protocol, address pointer, mode registers, read-ahead buffer and status.
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter logic [7:0] PORT_DATA = PORT_DATA_DEFAULT,
    parameter logic [7:0] PORT_CTRL = PORT_CTRL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_en,
    input  logic [7:0]  io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [7:0]  io_din,
    output logic [7:0]  io_dout,
    output logic        wait_n,
    output logic        vram_req,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic [63:0] regs,
    input  logic        frame_pulse,
    input  logic        coll_pulse,
    input  logic        fifth_pulse,
    input  logic [4:0]  fifth_num,
    output logic        int_n
);

    logic        sel_data_s, sel_ctrl_s, acc_s, new_s, needs_vram_s, hold_s;
    logic        busy_s, rd_done_s, end_data_s, end_ctrl_s, stall_s, fire_s;
    logic        q_valid_s, q_we_s;
    logic [13:0] q_addr_s, setup_ptr_s;
    logic [7:0]  q_wdata_s, status_s;

    logic [13:0] ptr_q, ptr_d;
    logic        toggle_q, toggle_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic        f_q, f_d, s5_q, s5_d, c_q, c_d;
    logic [4:0]  num_q, num_d;
    logic        done_q, done_d, held_q, held_d;
    logic        rd_data_q, rd_data_d, rd_ctrl_q, rd_ctrl_d;
    logic        int_n_q, int_n_d;

    // An access is consumed once; a stalled one is replayed from held_q without a new strobe.
    // A new access is also deferred for the cycle in which a previous read is being closed.
    assign sel_data_s   = (io_addr == PORT_DATA);
    assign sel_ctrl_s   = (io_addr == PORT_CTRL);
    assign acc_s        = (io_wr | io_rd) & (sel_data_s | sel_ctrl_s);
    assign new_s        = acc_s & ~done_q & (io_en | held_q);
    assign needs_vram_s = sel_data_s |
                          (sel_ctrl_s & io_wr & toggle_q & (io_din[7:6] == 2'b00));
    assign hold_s       = new_s & needs_vram_s;
    assign end_data_s   = rd_data_q & ~io_rd;
    assign end_ctrl_s   = rd_ctrl_q & ~io_rd;
    assign stall_s      = new_s & ((needs_vram_s & busy_s) | end_data_s | end_ctrl_s);
    assign fire_s       = new_s & ~stall_s;
    assign setup_ptr_s  = {io_din[5:0], latch_q};

    vdp_vram_if u_vram_if (
        .clk_i        (clk),
        .reset_i      (reset),
        .q_valid_i    (q_valid_s),
        .q_we_i       (q_we_s),
        .q_addr_i     (q_addr_s),
        .q_wdata_i    (q_wdata_s),
        .hold_i       (hold_s),
        .vram_ack_i   (vram_ack),
        .busy_o       (busy_s),
        .rd_done_o    (rd_done_s),
        .wait_n_o     (wait_n),
        .vram_req_o   (vram_req),
        .vram_we_o    (vram_we),
        .vram_addr_o  (vram_addr),
        .vram_wdata_o (vram_wdata)
    );

    // Status byte and port read mux
    always_comb begin
        status_s          = 8'h00;
        status_s[STAT_F]  = f_q;
        status_s[STAT_5S] = s5_q;
        status_s[STAT_C]  = c_q;
        if (s5_q) begin
            status_s[4:0] = num_q;
        end else begin
            status_s[4:0] = SPRITE_NONE;
        end
        if (sel_data_s) begin
            io_dout = buf_q;
        end else if (sel_ctrl_s) begin
            io_dout = status_s;
        end else begin
            io_dout = 8'h00;
        end
    end

    // Access sequencing: read completion first, then newly accepted accesses
    always_comb begin
        ptr_d     = ptr_q;
        toggle_d  = toggle_q;
        latch_d   = latch_q;
        buf_d     = buf_q;
        regs_d    = regs_q;
        rd_data_d = rd_data_q;
        rd_ctrl_d = rd_ctrl_q;
        q_valid_s = 1'b0;
        q_we_s    = 1'b0;
        q_addr_s  = ptr_q;
        q_wdata_s = io_din;
        if (rd_done_s) begin
            buf_d = vram_rdata;
        end else begin
            buf_d = buf_q;
        end
        if (end_data_s) begin
            q_valid_s = 1'b1;
            ptr_d     = ptr_next(ptr_q);
            toggle_d  = 1'b0;
            rd_data_d = 1'b0;
        end else if (end_ctrl_s) begin
            toggle_d  = 1'b0;
            rd_ctrl_d = 1'b0;
        end else if (fire_s) begin
            if (sel_data_s) begin
                if (io_wr) begin
                    q_valid_s = 1'b1;
                    q_we_s    = 1'b1;
                    buf_d     = io_din;
                    ptr_d     = ptr_next(ptr_q);
                    toggle_d  = 1'b0;
                end else begin
                    rd_data_d = 1'b1;
                end
            end else if (io_wr) begin
                if (!toggle_q) begin
                    latch_d  = io_din;
                    toggle_d = 1'b1;
                end else begin
                    toggle_d = 1'b0;
                    if (io_din[7]) begin
                        if (io_din[6:3] == 4'b0000) begin
                            regs_d[io_din[2:0]] = latch_q;
                        end else begin
                            regs_d = regs_q;
                        end
                    end else if (io_din[6]) begin
                        ptr_d = setup_ptr_s;
                    end else begin
                        q_valid_s = 1'b1;
                        q_addr_s  = setup_ptr_s;
                        ptr_d     = ptr_next(setup_ptr_s);
                    end
                end
            end else begin
                rd_ctrl_d = 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Access tracking, flags and interrupt; a flag set beats a status-read clear
    always_comb begin
        if (!(io_wr | io_rd)) begin
            done_d = 1'b0;
        end else if (fire_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
        if (stall_s) begin
            held_d = 1'b1;
        end else if (fire_s | ~acc_s) begin
            held_d = 1'b0;
        end else begin
            held_d = held_q;
        end
        f_d  = frame_pulse | (f_q & ~end_ctrl_s);
        c_d  = coll_pulse  | (c_q & ~end_ctrl_s);
        s5_d = fifth_pulse | (s5_q & ~end_ctrl_s);
        if (fifth_pulse) begin
            num_d = fifth_num;
        end else begin
            num_d = num_q;
        end
        int_n_d = ~(f_d & regs_d[REG_R1][R1_IE]);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 14'h0000;
            toggle_q  <= 1'b0;
            latch_q   <= 8'h00;
            buf_q     <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
            f_q       <= 1'b0;
            s5_q      <= 1'b0;
            c_q       <= 1'b0;
            num_q     <= 5'h00;
            done_q    <= 1'b0;
            held_q    <= 1'b0;
            rd_data_q <= 1'b0;
            rd_ctrl_q <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            ptr_q     <= ptr_d;
            toggle_q  <= toggle_d;
            latch_q   <= latch_d;
            buf_q     <= buf_d;
            regs_q    <= regs_d;
            f_q       <= f_d;
            s5_q      <= s5_d;
            c_q       <= c_d;
            num_q     <= num_d;
            done_q    <= done_d;
            held_q    <= held_d;
            rd_data_q <= rd_data_d;
            rd_ctrl_q <= rd_ctrl_d;
            int_n_q   <= int_n_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_regs
        assign regs[8*gi +: 8] = regs_q[gi];
    end

    assign int_n = int_n_q;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Scoreboard bench for vdp_port_ctrl: expected VRAM ops are queued as stimulus
// is driven and checked by a VRAM responder when each request is acknowledged.
module tb_vdp_port_ctrl;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } op_t;

    logic        clk, reset, io_en, io_wr, io_rd;
    logic [7:0]  io_addr, io_din, io_dout;
    logic        wait_n, vram_req, vram_we, vram_ack;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;
    logic [63:0] regs;
    logic        frame_pulse, coll_pulse, fifth_pulse, int_n;
    logic [4:0]  fifth_num;

    op_t        sb[$];
    op_t        exp_op;
    logic [7:0] mem [16384];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         ack_delay = 0;
    int         wcnt = 0;
    bit         no_ack = 1'b0;

    vdp_port_ctrl #(.PORT_DATA(8'h98), .PORT_CTRL(8'h99)) dut (
        .clk(clk), .reset(reset), .io_en(io_en), .io_addr(io_addr),
        .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout),
        .wait_n(wait_n), .vram_req(vram_req), .vram_we(vram_we),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .regs(regs), .frame_pulse(frame_pulse),
        .coll_pulse(coll_pulse), .fifth_pulse(fifth_pulse),
        .fifth_num(fifth_num), .int_n(int_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM responder: acknowledges after ack_delay cycles and pops the scoreboard
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = i[7:0] ^ 8'hC3;
        vram_ack = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(posedge clk); #3;
            if (vram_ack) begin
                vram_ack = 1'b0;
            end else if (reset) begin
                wcnt = 0;
            end else if (vram_req && !no_ack) begin
                if (wcnt >= ack_delay) begin
                    vec_cnt++;
                    if (sb.size() == 0) begin
                        err_cnt++;
                        $display("FAIL vram_op: got we=%0b addr=%h, want no request", vram_we, vram_addr);
                    end else begin
                        exp_op = sb.pop_front();
                        if (vram_we !== exp_op.we || vram_addr !== exp_op.addr ||
                            (exp_op.we && vram_wdata !== exp_op.data)) begin
                            err_cnt++;
                            $display("FAIL vram_op: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                                     vram_we, vram_addr, vram_wdata, exp_op.we, exp_op.addr, exp_op.data);
                        end
                    end
                    if (vram_we) mem[vram_addr] = vram_wdata;
                    vram_rdata = mem[vram_addr];
                    vram_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic push_op(input logic we, input logic [13:0] addr, input logic [7:0] data);
        sb.push_back('{we: we, addr: addr, data: data});
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, output int stalls, output logic req_seen);
        stalls = 0;
        io_addr = a; io_din = d; io_wr = 1'b1; io_en = 1'b1;
        @(posedge clk); #1; io_en = 1'b0; #1;
        req_seen = vram_req;
        while (!wait_n && stalls < 60) begin @(posedge clk); #2; stalls++; end
        if (stalls >= 60) begin
            vec_cnt++; err_cnt++;
            $display("FAIL write_wait_timeout: wait_n=%0b after 60 cycles, want 1", wait_n);
        end
        @(posedge clk); #1; io_en = 1'b1;
        @(posedge clk); #1; io_en = 1'b0; io_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic io_read(input logic [7:0] a, input bit pulse_c, output logic [7:0] d);
        int n = 0;
        io_addr = a; io_rd = 1'b1; io_en = 1'b1;
        @(posedge clk); #1; io_en = 1'b0; #1;
        while (!wait_n && n < 60) begin @(posedge clk); #2; n++; end
        if (n >= 60) begin
            vec_cnt++; err_cnt++;
            $display("FAIL read_wait_timeout: wait_n=%0b after 60 cycles, want 1", wait_n);
        end
        @(posedge clk); #2; d = io_dout;
        io_rd = 1'b0; coll_pulse = pulse_c;
        @(posedge clk); #1; coll_pulse = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((vram_req || vram_ack) && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            vec_cnt++; err_cnt++;
            $display("FAIL idle_timeout: vram_req=%0b after 100 cycles, want 0", vram_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; io_addr = 8'h98; #1;
        vec_cnt++; if (regs !== 64'h0) begin err_cnt++; $display("FAIL reset_regs: got %h want %h", regs, 64'h0); end
        vec_cnt++; if (vram_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", vram_req); end
        vec_cnt++; if (vram_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %b want 0", vram_we); end
        vec_cnt++; if (wait_n !== 1'b1) begin err_cnt++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
        vec_cnt++; if (int_n !== 1'b1) begin err_cnt++; $display("FAIL reset_int_n: got %b want 1", int_n); end
        vec_cnt++; if (io_dout !== 8'h00) begin err_cnt++; $display("FAIL reset_buffer: got %h want 00", io_dout); end
        io_addr = 8'h99; #1;
        vec_cnt++; if (io_dout !== 8'h1F) begin err_cnt++; $display("FAIL reset_status: got %h want 1f", io_dout); end
    endtask

    task automatic test_write_setup();
        int st; logic rq; logic [7:0] d;
        ack_delay = 2;
        io_write(8'h99, 8'h00, st, rq);
        io_write(8'h99, 8'h47, st, rq);
        push_op(1'b1, 14'h0700, 8'hAA);
        io_write(8'h98, 8'hAA, st, rq);
        vec_cnt++; if (rq !== 1'b1) begin err_cnt++; $display("FAIL queue_to_req: got %b want 1", rq); end
        push_op(1'b1, 14'h0701, 8'h55);
        io_write(8'h98, 8'h55, st, rq);
        wait_idle();
        push_op(1'b0, 14'h0702, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'h55) begin err_cnt++; $display("FAIL write_copies_buffer: got %h want 55", d); end
        wait_idle();
        push_op(1'b0, 14'h0703, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'hC1) begin err_cnt++; $display("FAIL prefetch_0702: got %h want c1", d); end
        wait_idle();
    endtask

    task automatic test_regs_int();
        int st; logic rq; logic [7:0] d;
        io_write(8'h99, 8'hE0, st, rq);
        io_write(8'h99, 8'h81, st, rq);
        vec_cnt++; if (regs[15:8] !== 8'hE0) begin err_cnt++; $display("FAIL r1_write: got %h want e0", regs[15:8]); end
        vec_cnt++; if (int_n !== 1'b1) begin err_cnt++; $display("FAIL int_idle: got %b want 1", int_n); end
        io_write(8'h99, 8'h5A, st, rq);
        io_write(8'h99, 8'h8A, st, rq);
        vec_cnt++; if (regs[23:8] !== 16'h00E0) begin err_cnt++; $display("FAIL reg_write_ignored: got %h want 00e0", regs[23:8]); end
        io_write(8'h99, 8'h33, st, rq);
        io_write(8'h99, 8'h87, st, rq);
        vec_cnt++; if (regs[63:56] !== 8'h33) begin err_cnt++; $display("FAIL r7_write: got %h want 33", regs[63:56]); end
        frame_pulse = 1'b1;
        @(posedge clk); #1; frame_pulse = 1'b0;
        vec_cnt++; if (int_n !== 1'b0) begin err_cnt++; $display("FAIL int_on_frame: got %b want 0", int_n); end
        io_write(8'h99, 8'h00, st, rq);
        io_write(8'h99, 8'h81, st, rq);
        vec_cnt++; if (int_n !== 1'b1) begin err_cnt++; $display("FAIL int_masked_by_r1: got %b want 1", int_n); end
        io_write(8'h99, 8'hE0, st, rq);
        io_write(8'h99, 8'h81, st, rq);
        vec_cnt++; if (int_n !== 1'b0) begin err_cnt++; $display("FAIL int_unmasked: got %b want 0", int_n); end
        io_read(8'h99, 1'b0, d);
        vec_cnt++; if (d !== 8'h9F) begin err_cnt++; $display("FAIL status_frame: got %h want 9f", d); end
        vec_cnt++; if (int_n !== 1'b1) begin err_cnt++; $display("FAIL int_cleared_by_read: got %b want 1", int_n); end
    endtask

    task automatic test_flags();
        logic [7:0] d;
        fifth_num = 5'h0A; coll_pulse = 1'b1; fifth_pulse = 1'b1;
        @(posedge clk); #1; coll_pulse = 1'b0; fifth_pulse = 1'b0; fifth_num = 5'h03;
        io_read(8'h99, 1'b1, d);
        vec_cnt++; if (d !== 8'h6A) begin err_cnt++; $display("FAIL status_5s_c: got %h want 6a", d); end
        io_read(8'h99, 1'b0, d);
        vec_cnt++; if (d !== 8'h3F) begin err_cnt++; $display("FAIL set_beats_clear: got %h want 3f", d); end
        io_read(8'h99, 1'b0, d);
        vec_cnt++; if (d !== 8'h1F) begin err_cnt++; $display("FAIL status_cleared: got %h want 1f", d); end
    endtask

    task automatic test_read_setup_wrap();
        int st; logic rq; logic [7:0] d;
        ack_delay = 1;
        mem[14'h3FFF] = 8'h12;
        push_op(1'b0, 14'h3FFF, 8'h00);
        io_write(8'h99, 8'hFF, st, rq);
        io_write(8'h99, 8'h3F, st, rq);
        wait_idle();
        push_op(1'b0, 14'h0000, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'h12) begin err_cnt++; $display("FAIL read_setup_buffer: got %h want 12", d); end
        wait_idle();
        push_op(1'b0, 14'h0001, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'hC3) begin err_cnt++; $display("FAIL wrap_prefetch: got %h want c3", d); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int st; logic rq;
        ack_delay = 10;
        push_op(1'b1, 14'h0002, 8'h11);
        io_write(8'h98, 8'h11, st, rq);
        push_op(1'b1, 14'h0003, 8'h22);
        io_write(8'h98, 8'h22, st, rq);
        vec_cnt++; if (st < 5 || st > 9) begin err_cnt++; $display("FAIL wait_stall_cycles: got %0d want 5..9", st); end
        wait_idle();
        ack_delay = 0;
    endtask

    task automatic test_toggle();
        int st; logic rq; logic [7:0] d;
        io_write(8'h99, 8'h01, st, rq);
        push_op(1'b0, 14'h0004, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'h22) begin err_cnt++; $display("FAIL toggle_data_read: got %h want 22", d); end
        wait_idle();
        io_write(8'h99, 8'h02, st, rq);
        io_write(8'h99, 8'h40, st, rq);
        push_op(1'b0, 14'h0002, 8'h00);
        io_read(8'h98, 1'b0, d);
        vec_cnt++; if (d !== 8'hC7) begin err_cnt++; $display("FAIL toggle_prefetch_0004: got %h want c7", d); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int st; logic rq;
        no_ack = 1'b1;
        io_write(8'h98, 8'h77, st, rq);
        vec_cnt++; if (vram_req !== 1'b1) begin err_cnt++; $display("FAIL mid_req_pending: got %b want 1", vram_req); end
        reset = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (vram_req !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_req: got %b want 0", vram_req); end
        vec_cnt++; if (regs !== 64'h0) begin err_cnt++; $display("FAIL mid_reset_regs: got %h want 0", regs); end
        vec_cnt++; if (io_dout !== 8'h00) begin err_cnt++; $display("FAIL mid_reset_buffer: got %h want 00", io_dout); end
        @(posedge clk); #1; reset = 1'b0; no_ack = 1'b0;
        push_op(1'b1, 14'h0000, 8'h5A);
        io_write(8'h98, 8'h5A, st, rq);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1; io_en = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
        io_addr = 8'h00; io_din = 8'h00;
        frame_pulse = 1'b0; coll_pulse = 1'b0; fifth_pulse = 1'b0; fifth_num = 5'h00;
        test_reset();
        test_write_setup();
        test_regs_int();
        test_flags();
        test_read_setup_wrap();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending ops, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
